ps2_fifo_sb_ctrl: RTL

//  System-bus PS/2 keyboard controller with built-in frame receiver and scan-code FIFO.

---
 rtl/ps2_fifo_sb_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_fifo_sb_ctrl.sv
// PS/2 keyboard controller for the peripheral bus: synchronised frame receiver,
// scan-code FIFO with status flags, and a threshold interrupt.
module ps2_fifo_sb_ctrl #(
  parameter int DEPTH       = 16,
  parameter int TIMEOUT_CYC = 100000,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] addr_i,
  input  logic        req_i,
  input  logic        write_enable_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        interrupt_request_o,
  input  logic        interrupt_return_i,
  input  logic        kclk_i,
  input  logic        kdata_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [31:0] ADDR_DATA = 32'h0000_0000;
  localparam logic [31:0] ADDR_STAT = 32'h0000_0004;
  localparam logic [31:0] ADDR_CTRL = 32'h0000_0008;
  localparam logic [31:0] ADDR_RST  = 32'h0000_0024;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  // Synchronisers: reset to the idle-high line level so no edge is seen on release
  logic [SYNC_STAGES-1:0] kclk_sync;
  logic [SYNC_STAGES-1:0] kdata_sync;
  logic                   kclk_prev;
  logic                   fall;
  logic                   kbit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      kclk_sync  <= '1;
      kdata_sync <= '1;
      kclk_prev  <= 1'b1;
    end else begin
      kclk_sync  <= {kclk_sync[SYNC_STAGES-2:0], kclk_i};
      kdata_sync <= {kdata_sync[SYNC_STAGES-2:0], kdata_i};
      kclk_prev  <= kclk_sync[SYNC_STAGES-1];
    end
  end

  assign fall = kclk_prev & ~kclk_sync[SYNC_STAGES-1];
  assign kbit = kdata_sync[SYNC_STAGES-1];

  // Frame receiver
  rx_state_t       rx_state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            parity_ok;
  logic [TO_W-1:0] to_cnt;
  logic            timeout;
  logic            stop_sample;
  logic            rx_push;
  logic            par_set;
  logic            frm_set;

  assign timeout = (rx_state != RX_IDLE) && !fall && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state  <= RX_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      parity_ok <= 1'b0;
      to_cnt    <= '0;
    end else begin
      if (rx_state == RX_IDLE || fall) to_cnt <= '0;
      else                             to_cnt <= to_cnt + 1'b1;

      if (timeout) begin
        rx_state <= RX_IDLE;
      end else if (fall) begin
        case (rx_state)
          RX_IDLE: begin
            if (!kbit) begin
              rx_state <= RX_DATA;
              bit_cnt  <= '0;
            end
          end
          RX_DATA: begin
            shift   <= {kbit, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) rx_state <= RX_PARITY;
          end
          RX_PARITY: begin
            parity_ok <= ^{shift, kbit};
            rx_state  <= RX_STOP;
          end
          RX_STOP: rx_state <= RX_IDLE;
          default: rx_state <= RX_IDLE;
        endcase
      end
    end
  end

  assign stop_sample = (rx_state == RX_STOP) && fall;
  assign rx_push     = stop_sample && parity_ok && kbit;
  assign par_set     = stop_sample && !parity_ok;
  assign frm_set     = (stop_sample && !kbit) || timeout;

  // Bus decode and FIFO control
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             par_err;
  logic             frm_err;
  logic             irq_en;
  logic [7:0]       thr;
  logic             pending;

  logic             read_req;
  logic             write_req;
  logic             empty;
  logic             full;
  logic             pop;
  logic             flush;
  logic             push_ok;
  logic             ovf_set;
  logic [2:0]       w1c;
  logic [7:0]       thr_eff;
  logic             cond;
  logic [31:0]      rd_mux;
  logic             unused_bits;

  assign read_req  = req_i & ~write_enable_i;
  assign write_req = req_i & write_enable_i;
  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign pop       = read_req && (addr_i == ADDR_DATA) && !empty;
  assign flush     = write_req && (addr_i == ADDR_RST) && write_data_i[0];
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
  assign push_ok   = rx_push && !flush && (!full || pop);
  assign ovf_set   = rx_push && !flush && full && !pop;
  assign w1c       = (write_req && (addr_i == ADDR_STAT)) ? write_data_i[4:2] : 3'b000;
  assign thr_eff   = (thr == 8'd0) ? 8'd1 : thr;
  assign cond      = irq_en && (8'(count) >= thr_eff);
  assign unused_bits = ^{write_data_i[31:16], write_data_i[7:5], write_data_i[1]};

  always_comb begin
    rd_mux = '0;
    case (addr_i)
      ADDR_DATA: if (!empty) rd_mux = {1'b1, 23'b0, mem[rd_ptr]};
      ADDR_STAT: rd_mux = {16'b0, 8'(count), 3'b0, frm_err, par_err, ovf, full, !empty};
      ADDR_CTRL: rd_mux = {16'b0, thr, 7'b0, irq_en};
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      ovf         <= 1'b0;
      par_err     <= 1'b0;
      frm_err     <= 1'b0;
      irq_en      <= 1'b1;
      thr         <= 8'd1;
      pending     <= 1'b0;
      read_data_o <= '0;
    end else begin
      if (read_req) read_data_o <= rd_mux;

      if (write_req && addr_i == ADDR_CTRL) begin
        irq_en <= write_data_i[0];
        thr    <= write_data_i[15:8];
      end

      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        count <= count + CNT_W'(push_ok) - CNT_W'(pop);
      end

      // Hardware set beats a same-cycle software clear
      ovf     <= ((flush ? 1'b0 : ovf & ~w1c[0])) | ovf_set;
      par_err <= ((flush ? 1'b0 : par_err & ~w1c[1])) | par_set;
      frm_err <= ((flush ? 1'b0 : frm_err & ~w1c[2])) | frm_set;

      pending <= cond && !interrupt_return_i && !flush;
    end
  end

  assign interrupt_request_o = pending;

endmodule
